// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// One shift-add (multiply) or restoring (divide) step per cycle, with
// operands reduced to magnitudes up front and the sign applied at the end.
// Divide-by-zero and signed overflow resolve in the IDLE cycle.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply stops once the
// remaining multiplier bits are all zero).
module ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            busy,
    output logic            stallreq
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_funct3;
    logic              r_neg;      // negate the selected result at the end
    logic [2*XLEN-1:0] r_acc;      // product, or {remainder, quotient}
    logic [2*XLEN-1:0] r_mcand;    // multiplicand, pre-shifted each step
    logic [XLEN-1:0]   r_opb;      // multiplier (consumed LSB first) or divisor

    // Operand decode for the instruction presented in IDLE
    logic            w_is_div, w_sa_en, w_sb_en, w_sa, w_sb;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_div0, w_ovf, w_special, w_neg_in;

    assign w_is_div  = funct3[2];
    assign w_sa_en   = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign w_sb_en   = w_is_div ? ~funct3[0] : ~funct3[1];
    assign w_sa      = w_sa_en & opa[XLEN-1];
    assign w_sb      = w_sb_en & opb[XLEN-1];
    assign w_mag_a   = w_sa ? ('0 - opa) : opa;
    assign w_mag_b   = w_sb ? ('0 - opb) : opb;
    assign w_div0    = w_is_div && (opb == '0);
    assign w_ovf     = w_is_div && ~funct3[0] && (opa == MIN_NEG) && (opb == '1);
    assign w_special = w_div0 | w_ovf;
    // REM follows the dividend sign; everything else negates on differing signs
    assign w_neg_in  = (w_is_div && funct3[1]) ? w_sa : (w_sa ^ w_sb);

    // One iteration step
    logic [2*XLEN-1:0] w_mul_acc, w_div_acc;
    logic [XLEN:0]     w_rem_sh, w_trial;
    logic              w_borrow;
    logic              w_last, w_finish;

    assign w_mul_acc = r_acc + (r_opb[0] ? r_mcand : '0);
    assign w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_opb};
    assign w_borrow  = w_trial[XLEN];
    assign w_div_acc = {(w_borrow ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0]),
                        r_acc[XLEN-2:0], ~w_borrow};
    assign w_last    = (r_cnt == LAST);

`ifdef MULDIV_EARLY_OUT_EN
    // Multiplicand is pre-shifted, so stopping early needs no final alignment
    assign w_finish = w_last | (~r_funct3[2] & ((r_opb >> 1) == '0));
`else
    assign w_finish = w_last;
`endif

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_special ? S_DONE : S_BUSY;
            S_BUSY:  if (w_finish) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register and datapath; rdy low freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_opb    <= '0;
        end else if (rdy) begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_funct3 <= funct3;
                        r_cnt    <= '0;
                        if (w_special) begin
                            r_neg   <= 1'b0;
                            r_acc   <= w_div0 ? {opa, {XLEN{1'b1}}} : {{XLEN{1'b0}}, MIN_NEG};
                            r_mcand <= '0;
                            r_opb   <= '0;
                        end else begin
                            r_neg   <= w_neg_in;
                            r_acc   <= w_is_div ? {{XLEN{1'b0}}, w_mag_a} : '0;
                            r_mcand <= {{XLEN{1'b0}}, w_mag_a};
                            r_opb   <= w_mag_b;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_funct3[2]) begin
                        r_acc <= w_div_acc;
                    end else begin
                        r_acc   <= w_mul_acc;
                        r_mcand <= r_mcand << 1;
                        r_opb   <= r_opb >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Final sign correction and result selection
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_dsel, w_dres, w_res;
    always_comb begin
        w_prod = r_neg ? ('0 - r_acc) : r_acc;
        w_dsel = r_funct3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
        w_dres = r_neg ? ('0 - w_dsel) : w_dsel;
        case (r_funct3)
            3'd0:    w_res = w_prod[XLEN-1:0];
            3'd1,
            3'd2,
            3'd3:    w_res = w_prod[2*XLEN-1:XLEN];
            default: w_res = w_dres;
        endcase
    end

    assign result       = (r_state == S_DONE) ? w_res : '0;
    assign result_valid = (r_state == S_DONE);
    assign busy         = (r_state == S_BUSY);
    assign stallreq     = ((r_state == S_IDLE) && start) || (r_state == S_BUSY);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv.
// A cycle-level reference (result from plain 64-bit arithmetic, latency
// from the operation class) is compared against the DUT every cycle;
// directed operations additionally pin literal results and latencies.
// Honours MULDIV_EARLY_OUT_EN for expected multiply latency.
module tb_ex_muldiv;
    logic        clk, rst, rdy, start;
    logic [2:0]  funct3;
    logic [31:0] opa, opb, result;
    logic        result_valid, busy, stallreq;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    bit chk_en  = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .start(start), .funct3(funct3),
        .opa(opa), .opb(opb), .result(result), .result_valid(result_valid),
        .busy(busy), .stallreq(stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_M76 = 4;
    localparam int LAT_MB2 = 3;
`else
    localparam int LAT_M76 = 33;
    localparam int LAT_MB2 = 33;
`endif

    // Architectural result of one M-extension instruction
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        case (f)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * ub;
            3'd3:       p = ua * ub;
            default:    p = 64'h0;
        endcase
        if (!f[2]) return (f == 3'd0) ? p[31:0] : p[63:32];
        if (b == 32'h0) return f[1] ? a : 32'hFFFFFFFF;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return f[1] ? 32'h0 : 32'h80000000;
        if (f[0]) return f[1] ? (a % b) : (a / b);
        return f[1] ? (ia % ib) : (ia / ib);
    endfunction

    // Cycle in which result_valid appears, counting the start cycle as 0
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] mb;
        int iters;
`endif
        if (f[2]) begin
            if (b == 32'h0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
            return 33;
        end
`ifdef MULDIV_EARLY_OUT_EN
        mb = (!f[1] && b[31]) ? (32'h0 - b) : b;
        iters = 1;
        for (int i = 0; i < 32; i++) if (mb[i]) iters = i + 1;
        return iters + 1;
`else
        return 33;
`endif
    endfunction

    typedef enum {P_IDLE, P_BUSY, P_DONE} phase_t;
    phase_t      m_phase = P_IDLE;
    int          m_left  = 0;
    logic [31:0] m_res   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= P_IDLE;
            m_left  <= 0;
        end else if (rdy) begin
            case (m_phase)
                P_IDLE: if (start) begin
                    m_res   <= ref_res(funct3, opa, opb);
                    m_left  <= ref_lat(funct3, opa, opb) - 1;
                    m_phase <= (ref_lat(funct3, opa, opb) == 1) ? P_DONE : P_BUSY;
                end
                P_BUSY: begin
                    m_left  <= m_left - 1;
                    m_phase <= (m_left == 1) ? P_DONE : P_BUSY;
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (result_valid) n_valid++;
        if (chk_en) begin
            check("cyc_busy", busy, m_phase == P_BUSY);
            check("cyc_valid", result_valid, m_phase == P_DONE);
            check("cyc_stallreq", stallreq, (m_phase == P_IDLE && start) || m_phase == P_BUSY);
            if (m_phase == P_DONE) check("cyc_result", result, m_res);
        end
    end

    // Called at posedge+1; presents one instruction and follows it to completion
    task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                         input int rdy_at, input int drop_at, input bit keep);
        int  stall_cnt;
        bit  seen;
        stall_cnt = 0;
        seen      = 0;
        funct3 = f;
        opa    = a;
        opb    = b;
        start  = 1'b1;
        for (int c = 0; c <= 200 && !seen; c++) begin
            if (c == rdy_at) rdy = 1'b0;
            if (rdy_at >= 0 && c == rdy_at + 5) rdy = 1'b1;
            if (c == drop_at) start = 1'b0;
            #1;
            if (result_valid) begin
                seen = 1;
                check({nm, "_lat"}, c, exp_lat);
                check({nm, "_res"}, result, exp_res);
                check({nm, "_stall_done"}, stallreq, 0);
                check({nm, "_stall_cycles"}, stall_cnt, exp_lat);
            end else if (stallreq) begin
                stall_cnt++;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no result_valid, expected one by cycle %0d", nm, exp_lat);
            rdy = 1'b1;
        end
        if (!keep) start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [2:0]  f;
        logic [31:0] a, b;
        int lat, rdy_at, drop_at;

        rst = 1'b1; rdy = 1'b1; start = 1'b0; funct3 = '0; opa = '0; opb = '0;
        #2;
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_stallreq", stallreq, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1;

        do_op("mul_7_6", 3'd0, 32'd7, 32'd6, 32'd42, LAT_M76, -1, -1, 0);
        do_op("mulh_m1_2", 3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, LAT_MB2, -1, -1, 0);
        do_op("mulhu_m1_2", 3'd3, 32'hFFFFFFFF, 32'd2, 32'h00000001, LAT_MB2, -1, -1, 0);
        do_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, -1, -1, 0);
        do_op("divu_5_0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1, -1, -1, 0);
        do_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, -1, -1, 0);
        do_op("remu_drop", 3'd7, 32'd100, 32'd7, 32'd2, 33, -1, 5, 0);

        p0 = n_valid;
        do_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, -1, -1, 1);
        do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33, -1, -1, 0);
        check("two_pulses", n_valid - p0, 2);

        do_op("mul_rdy_stall", 3'd0, 32'd3, 32'h80000000, 32'h80000000, 38, 10, -1, 0);

        funct3 = 3'd0; opa = 32'd3; opb = 32'h80000000; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        p0 = n_valid;
        rst = 1'b1;
        start = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", result_valid, 0);
        check("midrst_stallreq", stallreq, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_pulse", n_valid - p0, 0);

        for (int k = 0; k < 40; k++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin
                    a = $urandom_range(0, 1) ? (32'h0 - $urandom_range(0, 300)) : $urandom_range(0, 300);
                    b = $urandom_range(0, 1) ? (32'h0 - $urandom_range(1, 20)) : $urandom_range(1, 20);
                end
                default: ;
            endcase
            lat     = ref_lat(f, a, b);
            rdy_at  = ($urandom_range(0, 3) == 0 && lat > 3) ? $urandom_range(1, lat - 1) : -1;
            drop_at = ($urandom_range(0, 3) == 0 && lat > 2) ? 2 : -1;
            do_op("rand", f, a, b, ref_res(f, a, b), lat + ((rdy_at > 0) ? 5 : 0),
                  rdy_at, drop_at, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
